// File: rtl/can_tx_mailbox_arbiter.sv
// CAN transmit mailbox arbiter: holds NUM_MB host-written frames, offers the
// highest-priority pending frame (lowest standard ID, then lowest index) to the
// TX engine over valid/ready, and retires, re-queues or fails it on the outcome.
module can_tx_mailbox_arbiter #(
  parameter int NUM_MB    = 4,
  parameter int MAX_RETRY = 3,
  localparam int IDXW     = $clog2(NUM_MB)
) (
  input  logic              i_sys_clk,
  input  logic              i_reset_n,
  input  logic              i_cen,
  input  logic              i_wr_en,
  input  logic [IDXW-1:0]   i_wr_idx,
  input  logic [127:0]      i_wr_data,
  input  logic [NUM_MB-1:0] i_abort,
  output logic [NUM_MB-1:0] o_mb_pending,
  output logic              o_wr_reject,
  output logic [127:0]      o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  input  logic              i_tx_done,
  input  logic              i_tx_lost,
  input  logic              i_tx_error,
  output logic [IDXW-1:0]   o_sel_idx,
  output logic [NUM_MB-1:0] o_tx_ok,
  output logic [NUM_MB-1:0] o_tx_fail
);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_OFFER, S_ACTIVE} state_t;

  state_t              state, state_nxt;
  logic [127:0]        mb_data  [NUM_MB];
  logic [3:0]          retry    [NUM_MB];
  logic [NUM_MB-1:0]   abort_flag;
  logic [NUM_MB-1:0]   eligible;
  logic                win_found;
  logic [IDXW-1:0]     win_idx;
  logic [10:0]         win_id;
  logic                in_flight, wr_hit, wr_ok;
  logic                out_done, out_err, out_lost, abort_eff, err_fail;
  logic [3:0]          retry_inc;

  assign in_flight  = (state == S_OFFER) || (state == S_ACTIVE);
  assign wr_hit     = i_wr_en && in_flight && (i_wr_idx == o_sel_idx);
  assign wr_ok      = i_wr_en && !wr_hit;
  assign o_tx_valid = (state == S_OFFER);

  // Outcome decode with priority done > error > lost; only meaningful in ACTIVE.
  assign out_done  = (state == S_ACTIVE) && i_tx_done;
  assign out_err   = (state == S_ACTIVE) && i_tx_error && !i_tx_done;
  assign out_lost  = (state == S_ACTIVE) && i_tx_lost && !i_tx_done && !i_tx_error;
  // An abort arriving in the same cycle as the outcome still counts.
  assign abort_eff = abort_flag[o_sel_idx] || i_abort[o_sel_idx];
  assign retry_inc = (retry[o_sel_idx] == 4'hF) ? 4'hF : retry[o_sel_idx] + 4'd1;
  assign err_fail  = abort_eff || (retry_inc >= 4'(MAX_RETRY));

  // Priority pick: lowest ID wins, strict compare keeps the lowest index on ties.
  // Mailboxes being aborted this cycle are not eligible.
  always_comb begin
    eligible  = o_mb_pending & ~i_abort;
    win_found = 1'b0;
    win_idx   = '0;
    win_id    = '1;
    for (int i = 0; i < NUM_MB; i++) begin
      if (eligible[i] && (!win_found || mb_data[i][127:117] < win_id)) begin
        win_found = 1'b1;
        win_idx   = IDXW'(i);
        win_id    = mb_data[i][127:117];
      end
    end
  end

  // State register.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) state <= S_IDLE;
    else            state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (i_cen && |o_mb_pending) state_nxt = S_SELECT;
      S_SELECT: state_nxt = win_found ? S_OFFER : S_IDLE;
      S_OFFER:  if (i_tx_ready) state_nxt = S_ACTIVE;
      S_ACTIVE: if (i_tx_done || i_tx_lost || i_tx_error) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Latch the winner's index and frame; held stable through OFFER/ACTIVE.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_sel_idx <= '0;
      o_tx_data <= '0;
    end else if (state == S_SELECT && win_found) begin
      o_sel_idx <= win_idx;
      o_tx_data <= mb_data[win_idx];
    end
  end

  // Mailbox state: host writes, aborts, and retirement of the in-flight frame.
  always_ff @(posedge i_sys_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_mb_pending <= '0;
      abort_flag   <= '0;
      o_tx_ok      <= '0;
      o_tx_fail    <= '0;
      o_wr_reject  <= 1'b0;
      for (int i = 0; i < NUM_MB; i++) begin
        mb_data[i] <= '0;
        retry[i]   <= '0;
      end
    end else begin
      o_tx_ok     <= '0;
      o_tx_fail   <= '0;
      o_wr_reject <= wr_hit;
      for (int i = 0; i < NUM_MB; i++) begin
        if (wr_ok && i_wr_idx == IDXW'(i)) begin
          // A write wins over an abort to the same idle mailbox.
          mb_data[i]      <= i_wr_data;
          o_mb_pending[i] <= 1'b1;
          retry[i]        <= '0;
          abort_flag[i]   <= 1'b0;
        end else if (i_abort[i]) begin
          if (in_flight && o_sel_idx == IDXW'(i)) begin
            abort_flag[i] <= 1'b1;
          end else if (o_mb_pending[i]) begin
            o_mb_pending[i] <= 1'b0;
            o_tx_fail[i]    <= 1'b1;
            retry[i]        <= '0;
          end
        end
      end
      // The in-flight mailbox cannot be written, so these never collide with the loop.
      if (out_done) begin
        o_mb_pending[o_sel_idx] <= 1'b0;
        o_tx_ok[o_sel_idx]      <= 1'b1;
        retry[o_sel_idx]        <= '0;
        abort_flag[o_sel_idx]   <= 1'b0;
      end else if (out_err) begin
        if (err_fail) begin
          o_mb_pending[o_sel_idx] <= 1'b0;
          o_tx_fail[o_sel_idx]    <= 1'b1;
          retry[o_sel_idx]        <= '0;
          abort_flag[o_sel_idx]   <= 1'b0;
        end else begin
          retry[o_sel_idx] <= retry_inc;
        end
      end else if (out_lost && abort_eff) begin
        o_mb_pending[o_sel_idx] <= 1'b0;
        o_tx_fail[o_sel_idx]    <= 1'b1;
        retry[o_sel_idx]        <= '0;
        abort_flag[o_sel_idx]   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_can_tx_mailbox_arbiter.sv
// Directed bench for can_tx_mailbox_arbiter (NUM_MB=4, MAX_RETRY=3).
module tb_can_tx_mailbox_arbiter;
  localparam int NUM_MB = 4;
  localparam int IDXW   = 2;

  logic              i_sys_clk = 1'b0;
  logic              i_reset_n;
  logic              i_cen;
  logic              i_wr_en;
  logic [IDXW-1:0]   i_wr_idx;
  logic [127:0]      i_wr_data;
  logic [NUM_MB-1:0] i_abort;
  logic [NUM_MB-1:0] o_mb_pending;
  logic              o_wr_reject;
  logic [127:0]      o_tx_data;
  logic              o_tx_valid;
  logic              i_tx_ready;
  logic              i_tx_done;
  logic              i_tx_lost;
  logic              i_tx_error;
  logic [IDXW-1:0]   o_sel_idx;
  logic [NUM_MB-1:0] o_tx_ok;
  logic [NUM_MB-1:0] o_tx_fail;

  int checks = 0;
  int failures = 0;

  can_tx_mailbox_arbiter #(.NUM_MB(4), .MAX_RETRY(3)) dut (
    .i_sys_clk(i_sys_clk), .i_reset_n(i_reset_n), .i_cen(i_cen),
    .i_wr_en(i_wr_en), .i_wr_idx(i_wr_idx), .i_wr_data(i_wr_data),
    .i_abort(i_abort), .o_mb_pending(o_mb_pending), .o_wr_reject(o_wr_reject),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
    .i_tx_done(i_tx_done), .i_tx_lost(i_tx_lost), .i_tx_error(i_tx_error),
    .o_sel_idx(o_sel_idx), .o_tx_ok(o_tx_ok), .o_tx_fail(o_tx_fail)
  );

  always #5 i_sys_clk = ~i_sys_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] frm(input logic [10:0] id);
    return {id, {9{id}}, 18'(id)};
  endfunction

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge i_sys_clk);
    #1;
  endtask

  task automatic wr(input logic [IDXW-1:0] idx, input logic [10:0] id);
    i_wr_en = 1'b1; i_wr_idx = idx; i_wr_data = frm(id);
    step();
    i_wr_en = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 20; k++) begin
      if (o_tx_valid) break;
      step();
    end
    chk(tag, o_tx_valid, 1'b1);
  endtask

  // 0=done 1=lost 2=error, one-cycle pulse.
  task automatic outcome(input int kind);
    i_tx_done  = (kind == 0);
    i_tx_lost  = (kind == 1);
    i_tx_error = (kind == 2);
    step();
    i_tx_done = 1'b0; i_tx_lost = 1'b0; i_tx_error = 1'b0;
  endtask

  initial begin
    int seen;
    i_reset_n = 1'b0; i_cen = 1'b1; i_wr_en = 1'b0; i_wr_idx = '0; i_wr_data = '0;
    i_abort = '0; i_tx_ready = 1'b1; i_tx_done = 1'b0; i_tx_lost = 1'b0; i_tx_error = 1'b0;
    repeat (3) step();
    i_reset_n = 1'b1;
    step();
    chk("rst_pending", o_mb_pending, 4'b0000);
    chk("rst_valid", o_tx_valid, 1'b0);
    chk("rst_data", o_tx_data, 128'd0);
    chk("rst_ok_fail", {o_tx_ok, o_tx_fail, o_wr_reject}, 9'd0);

    // 1: latency and single done
    wr(2'd0, 11'h123);
    chk("t1_pend_n1", o_mb_pending, 4'b0001);
    chk("t1_valid_n1", o_tx_valid, 1'b0);
    step();
    chk("t1_valid_n2", o_tx_valid, 1'b0);
    step();
    chk("t1_valid_n3", o_tx_valid, 1'b1);
    chk("t1_sel", o_sel_idx, 2'd0);
    chk("t1_data", o_tx_data, frm(11'h123));
    step();
    chk("t1_valid_drop", o_tx_valid, 1'b0);
    outcome(0);
    chk("t1_ok", o_tx_ok, 4'b0001);
    chk("t1_pend", o_mb_pending, 4'b0000);
    step();
    chk("t1_ok_pulse", o_tx_ok, 4'b0000);

    // 2: priority order MB2, MB3, MB1
    i_cen = 1'b0;
    wr(2'd1, 11'h200); wr(2'd2, 11'h050); wr(2'd3, 11'h050);
    chk("t2_pend", o_mb_pending, 4'b1110);
    i_cen = 1'b1;
    wait_valid("t2_v0"); chk("t2_sel0", o_sel_idx, 2'd2);
    step(); outcome(0); chk("t2_ok0", o_tx_ok, 4'b0100);
    wait_valid("t2_v1"); chk("t2_sel1", o_sel_idx, 2'd3);
    step(); outcome(0); chk("t2_ok1", o_tx_ok, 4'b1000);
    wait_valid("t2_v2"); chk("t2_sel2", o_sel_idx, 2'd1);
    chk("t2_data2", o_tx_data, frm(11'h200));
    step(); outcome(0); chk("t2_ok2", o_tx_ok, 4'b0010);

    // 3: lost while a higher-priority frame arrives
    wr(2'd0, 11'h300);
    wait_valid("t3_v0"); chk("t3_sel0", o_sel_idx, 2'd0);
    step();
    i_wr_en = 1'b1; i_wr_idx = 2'd1; i_wr_data = frm(11'h001);
    outcome(1);
    i_wr_en = 1'b0;
    chk("t3_pend", o_mb_pending, 4'b0011);
    chk("t3_nofail", o_tx_fail, 4'b0000);
    wait_valid("t3_v1"); chk("t3_sel1", o_sel_idx, 2'd1);
    step(); outcome(0);
    wait_valid("t3_v2"); chk("t3_sel2", o_sel_idx, 2'd0);
    chk("t3_data2", o_tx_data, frm(11'h300));
    step(); outcome(0);
    chk("t3_ok", o_tx_ok, 4'b0001);
    chk("t3_empty", o_mb_pending, 4'b0000);

    // 4: retries exhausted
    wr(2'd0, 11'h123);
    for (int k = 0; k < 3; k++) begin
      wait_valid("t4_v"); chk("t4_sel", o_sel_idx, 2'd0);
      step(); outcome(2);
      if (k < 2) begin
        chk("t4_keep", o_mb_pending, 4'b0001);
        chk("t4_nofail", o_tx_fail, 4'b0000);
      end else begin
        chk("t4_fail", o_tx_fail, 4'b0001);
        chk("t4_drop", o_mb_pending, 4'b0000);
      end
    end
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (o_tx_valid) seen++;
    end
    chk("t4_no4th", seen, 0);

    // 5: reject, abort in flight, abort idle, write beats abort
    wr(2'd1, 11'h100);
    wait_valid("t5_v"); chk("t5_sel", o_sel_idx, 2'd1);
    i_wr_en = 1'b1; i_wr_idx = 2'd1; i_wr_data = frm(11'h7FF);
    step();
    i_wr_en = 1'b0;
    chk("t5_reject", o_wr_reject, 1'b1);
    chk("t5_data", o_tx_data, frm(11'h100));
    i_abort = 4'b0010;
    step();
    i_abort = '0;
    chk("t5_reject_pulse", o_wr_reject, 1'b0);
    chk("t5_still_pend", o_mb_pending, 4'b0010);
    outcome(2);
    chk("t5_abort_fail", o_tx_fail, 4'b0010);
    chk("t5_abort_drop", o_mb_pending, 4'b0000);
    i_cen = 1'b0;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (o_tx_valid) seen++;
    end
    chk("t5_no_retry", seen, 0);
    wr(2'd2, 11'h010);
    i_abort = 4'b0100;
    step();
    i_abort = '0;
    chk("t5_idle_fail", o_tx_fail, 4'b0100);
    chk("t5_idle_drop", o_mb_pending, 4'b0000);
    i_wr_en = 1'b1; i_wr_idx = 2'd3; i_wr_data = frm(11'h444); i_abort = 4'b1000;
    step();
    i_wr_en = 1'b0; i_abort = '0;
    chk("t5_wr_wins_pend", o_mb_pending, 4'b1000);
    chk("t5_wr_wins_fail", o_tx_fail, 4'b0000);

    // 6: cen gating and reset during OFFER
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (o_tx_valid) seen++;
    end
    chk("t6_cen_off", seen, 0);
    i_tx_ready = 1'b0; i_cen = 1'b1;
    wait_valid("t6_v"); chk("t6_sel", o_sel_idx, 2'd3);
    i_reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", o_tx_valid, 1'b0);
    chk("t6_rst_pend", o_mb_pending, 4'b0000);
    chk("t6_rst_data", o_tx_data, 128'd0);
    step();
    chk("t6_rst_pulses", {o_tx_ok, o_tx_fail}, 8'd0);
    i_reset_n = 1'b1; i_tx_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (o_tx_valid) seen++;
    end
    chk("t6_after_rst", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
